// File: rtl/read_port.sv
// read_port: egress serialiser for one output port.
// Accepts a packet descriptor (length in 16-bit words), pulls 128-bit
// corrected SRAM lines over a valid/ready handshake and emits the packet
// one word per beat under downstream rd_ready backpressure, marking the
// first beat with rd_sop and the last with rd_eop.
//
// Optional build macro READ_PORT_PREFETCH_EN adds a one-line prefetch
// register.
//   - With the macro: the next line is fetched while the current line
//     drains, so line boundaries inside a packet cost no bubble.
//   - Without the macro: every line boundary inside a packet costs one
//     idle cycle (rd_vld=0).

module read_port #(
    parameter int DATA_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_vld,
    output logic                  pkt_rdy,
    input  logic [LEN_WIDTH-1:0]  pkt_length,
    input  logic                  line_vld,
    output logic                  line_rdy,
    input  logic [LINE_WIDTH-1:0] line_data,
    input  logic                  rd_ready,
    output logic                  rd_vld,
    output logic                  rd_sop,
    output logic                  rd_eop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy
);

    localparam int WORDS_PER_LINE = LINE_WIDTH / DATA_WIDTH;
    localparam int IDX_WIDTH      = $clog2(WORDS_PER_LINE);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(WORDS_PER_LINE - 1);
    localparam logic [IDX_WIDTH-1:0] ZERO_IDX   = {IDX_WIDTH{1'b0}};
    localparam logic [IDX_WIDTH-1:0] ONE_IDX    = IDX_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ONE_WORD   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] ZERO_LEN   = {LEN_WIDTH{1'b0}};
    localparam logic [LINE_WIDTH-1:0] ZERO_LINE = {LINE_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                  state_r,     state_s;
    logic [LEN_WIDTH-1:0]    remaining_r, remaining_s;
    logic [IDX_WIDTH-1:0]    idx_r,       idx_s;
    logic                    first_r,     first_s;
    logic [LINE_WIDTH-1:0]   buf_r,       buf_s;

`ifdef READ_PORT_PREFETCH_EN
    logic [LINE_WIDTH-1:0]   pf_r,        pf_s;
    logic                    pf_full_r,   pf_full_s;
    logic                    line_hs_s;
`endif

    // Output decode straight from registered state, no input-to-output paths.
    assign pkt_rdy = (state_r == IDLE);
    assign rd_vld  = (state_r == SEND);
    assign rd_sop  = (state_r == SEND) && first_r;
    assign rd_eop  = (state_r == SEND) && (remaining_r == ONE_WORD);
    assign rd_data = buf_r[DATA_WIDTH*idx_r +: DATA_WIDTH];
    assign busy    = (state_r != IDLE);

`ifdef READ_PORT_PREFETCH_EN
    // While sending, ask for a line only if the packet still needs words
    // beyond the ones left in the current line and the prefetch slot is free.
    assign line_rdy = (state_r == FETCH) ||
                      ((state_r == SEND) && !pf_full_r &&
                       (remaining_r > (LEN_WIDTH'(WORDS_PER_LINE) - LEN_WIDTH'(idx_r))));
    assign line_hs_s = line_vld && line_rdy;
`else
    assign line_rdy = (state_r == FETCH);
`endif

    // Next-state and datapath update for the descriptor/line/word handshakes.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        idx_s       = idx_r;
        first_s     = first_r;
        buf_s       = buf_r;
`ifdef READ_PORT_PREFETCH_EN
        pf_s        = pf_r;
        pf_full_s   = pf_full_r;
`endif
        case (state_r)
            IDLE: begin
                if (pkt_vld) begin
                    remaining_s = pkt_length;
                    first_s     = 1'b1;
                    idx_s       = ZERO_IDX;
                    // A zero-length descriptor is consumed and dropped.
                    if (pkt_length != ZERO_LEN) begin
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (line_vld) begin
                    buf_s   = line_data;
                    idx_s   = ZERO_IDX;
                    state_s = SEND;
                end else begin
                    state_s = FETCH;
                end
            end
            SEND: begin
`ifdef READ_PORT_PREFETCH_EN
                if (line_hs_s) begin
                    pf_s      = line_data;
                    pf_full_s = 1'b1;
                end else begin
                    pf_s      = pf_r;
                end
`endif
                if (rd_ready) begin
                    remaining_s = remaining_r - ONE_WORD;
                    first_s     = 1'b0;
                    if (remaining_r == ONE_WORD) begin
                        // Last word: any unused words left in the line are dropped.
                        state_s = IDLE;
`ifdef READ_PORT_PREFETCH_EN
                        pf_full_s = 1'b0;
`endif
                    end else if (idx_r == LAST_IDX) begin
`ifdef READ_PORT_PREFETCH_EN
                        if (pf_full_r) begin
                            buf_s     = pf_r;
                            pf_full_s = 1'b0;
                            idx_s     = ZERO_IDX;
                            state_s   = SEND;
                        end else if (line_hs_s) begin
                            // Line arriving exactly at the boundary goes straight
                            // into the send buffer rather than the prefetch slot.
                            buf_s     = line_data;
                            pf_full_s = 1'b0;
                            idx_s     = ZERO_IDX;
                            state_s   = SEND;
                        end else begin
                            state_s   = FETCH;
                        end
`else
                        state_s = FETCH;
`endif
                    end else begin
                        idx_s = idx_r + ONE_IDX;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= ZERO_LEN;
            idx_r       <= ZERO_IDX;
            first_r     <= 1'b0;
            buf_r       <= ZERO_LINE;
`ifdef READ_PORT_PREFETCH_EN
            pf_r        <= ZERO_LINE;
            pf_full_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            idx_r       <= idx_s;
            first_r     <= first_s;
            buf_r       <= buf_s;
`ifdef READ_PORT_PREFETCH_EN
            pf_r        <= pf_s;
            pf_full_r   <= pf_full_s;
`endif
        end
    end

endmodule

// File: tb/tb_read_port.sv
// Directed bench for read_port: reset state, single-line packets, multi-line
// packet with line-boundary timing, backpressure hold, zero length, and
// reset in the middle of a packet.

module tb_read_port;

    logic         clk = 1'b0;
    logic         rst;
    logic         pkt_vld;
    logic         pkt_rdy;
    logic [8:0]   pkt_length;
    logic         line_vld;
    logic         line_rdy;
    logic [127:0] line_data;
    logic         rd_ready;
    logic         rd_vld;
    logic         rd_sop;
    logic         rd_eop;
    logic [15:0]  rd_data;
    logic         busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] beat_data[$];
    logic        beat_sop[$];
    logic        beat_eop[$];
    int          beat_cyc[$];
    int          cyc = 0;
    int          line_cnt = 0;
    logic        line_hs_pend = 1'b0;
    int          line_base = 0;
    logic [15:0] pkt_base = 16'h0000;

    read_port dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_vld    (pkt_vld),
        .pkt_rdy    (pkt_rdy),
        .pkt_length (pkt_length),
        .line_vld   (line_vld),
        .line_rdy   (line_rdy),
        .line_data  (line_data),
        .rd_ready   (rd_ready),
        .rd_vld     (rd_vld),
        .rd_sop     (rd_sop),
        .rd_eop     (rd_eop),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] make_line(input logic [15:0] first);
        logic [127:0] l;
        l = 128'd0;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = first + 16'(k);
        return l;
    endfunction

    // Line n of the current packet carries words base+8n .. base+8n+7.
    assign line_data = make_line(pkt_base + 16'(8 * (line_cnt - line_base)));

    // Record word transfers and pending line handshakes away from the edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && rd_vld && rd_ready) begin
            beat_data.push_back(rd_data);
            beat_sop.push_back(rd_sop);
            beat_eop.push_back(rd_eop);
            beat_cyc.push_back(cyc);
        end
        line_hs_pend <= !rst && line_vld && line_rdy;
    end

    // Advance the line source once the pending handshake completes.
    always @(posedge clk) begin
        if (line_hs_pend) line_cnt <= line_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_desc(input logic [8:0] len, input logic [15:0] base);
        int k;
        pkt_base   = base;
        line_base  = line_cnt;
        pkt_length = len;
        pkt_vld    = 1'b1;
        k = 0;
        while (!pkt_rdy && k < 50) begin
            step(1);
            k++;
        end
        check_eq("desc_rdy", 32'(pkt_rdy), 32'd1);
        step(1);
        pkt_vld = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beat_data.size() < n && k < 200) begin
            step(1);
            k++;
        end
        check_eq("beats_tmo", 32'(beat_data.size() >= n), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_pkt_rdy"},  32'(pkt_rdy),  32'd1);
        check_eq({tag, "_line_rdy"}, 32'(line_rdy), 32'd0);
        check_eq({tag, "_rd_vld"},   32'(rd_vld),   32'd0);
        check_eq({tag, "_rd_sop"},   32'(rd_sop),   32'd0);
        check_eq({tag, "_rd_eop"},   32'(rd_eop),   32'd0);
        check_eq({tag, "_rd_data"},  32'(rd_data),  32'd0);
        check_eq({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    initial begin
        int s;
        int exp_gap;
        int n_eop;

        rst        = 1'b1;
        pkt_vld    = 1'b0;
        pkt_length = 9'd0;
        line_vld   = 1'b0;
        rd_ready   = 1'b0;
        step(3);
        rst = 1'b0;
        check_idle_outputs("reset");

        line_vld = 1'b1;
        rd_ready = 1'b1;

        // Length 8: one full line.
        s = beat_data.size();
        send_desc(9'd8, 16'h1000);
        wait_beats(s + 8);
        check_eq("t1_pkt_rdy", 32'(pkt_rdy), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);
        check_eq("t1_lines", 32'(line_cnt - line_base), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("t1_data", 32'(beat_data[s+i]), 32'h1000 + 32'(i));
            check_eq("t1_sop", 32'(beat_sop[s+i]), 32'(i == 0));
            check_eq("t1_eop", 32'(beat_eop[s+i]), 32'(i == 7));
        end

        // Length 3: partial line, trailing words dropped.
        s = beat_data.size();
        send_desc(9'd3, 16'h00A0);
        wait_beats(s + 3);
        step(2);
        check_eq("t2_count", 32'(beat_data.size() - s), 32'd3);
        check_eq("t2_d0", 32'(beat_data[s]),   32'h00A0);
        check_eq("t2_d1", 32'(beat_data[s+1]), 32'h00A1);
        check_eq("t2_d2", 32'(beat_data[s+2]), 32'h00A2);
        check_eq("t2_sop", 32'(beat_sop[s]), 32'd1);
        check_eq("t2_eop_mid", 32'(beat_eop[s+1]), 32'd0);
        check_eq("t2_eop", 32'(beat_eop[s+2]), 32'd1);
        check_eq("t2_lines", 32'(line_cnt - line_base), 32'd1);
        check_eq("t2_busy", 32'(busy), 32'd0);

        // Length 20: three lines, check order and boundary bubbles.
        s = beat_data.size();
        send_desc(9'd20, 16'h2000);
        wait_beats(s + 20);
        check_eq("t3_lines", 32'(line_cnt - line_base), 32'd3);
        for (int i = 0; i < 20; i++) begin
            check_eq("t3_data", 32'(beat_data[s+i]), 32'h2000 + 32'(i));
        end
        check_eq("t3_eop", 32'(beat_eop[s+19]), 32'd1);
        for (int i = 1; i < 20; i++) begin
`ifdef READ_PORT_PREFETCH_EN
            exp_gap = 1;
`else
            exp_gap = (i == 8 || i == 16) ? 2 : 1;
`endif
            check_eq("t3_gap", 32'(beat_cyc[s+i] - beat_cyc[s+i-1]), 32'(exp_gap));
        end

        // Length 12 with a 5-cycle stall while word 3 is presented.
        s = beat_data.size();
        send_desc(9'd12, 16'h3000);
        wait_beats(s + 3);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t4_hold_vld", 32'(rd_vld), 32'd1);
            check_eq("t4_hold_data", 32'(rd_data), 32'h3003);
            check_eq("t4_hold_eop", 32'(rd_eop), 32'd0);
        end
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        wait_beats(s + 12);
        step(3);
        check_eq("t4_count", 32'(beat_data.size() - s), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check_eq("t4_data", 32'(beat_data[s+i]), 32'h3000 + 32'(i));
        end
        check_eq("t4_lines", 32'(line_cnt - line_base), 32'd2);

        // Length 0: descriptor consumed, nothing fetched or sent.
        s = beat_data.size();
        send_desc(9'd0, 16'h0000);
        check_eq("t5_pkt_rdy", 32'(pkt_rdy), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_line_rdy", 32'(line_rdy), 32'd0);
        step(4);
        check_eq("t5_beats", 32'(beat_data.size() - s), 32'd0);
        check_eq("t5_lines", 32'(line_cnt - line_base), 32'd0);

        // Length 16 abandoned by reset after beat 5, then a clean length-2 packet.
        s = beat_data.size();
        send_desc(9'd16, 16'h4000);
        wait_beats(s + 5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_idle_outputs("t6_rst");
        check_eq("t6_beats", 32'(beat_data.size() - s), 32'd5);
        n_eop = 0;
        for (int i = s; i < beat_data.size(); i++) n_eop += int'(beat_eop[i]);
        check_eq("t6_no_eop", 32'(n_eop), 32'd0);

        s = beat_data.size();
        send_desc(9'd2, 16'h5000);
        wait_beats(s + 2);
        step(2);
        check_eq("t6b_count", 32'(beat_data.size() - s), 32'd2);
        check_eq("t6b_d0", 32'(beat_data[s]),   32'h5000);
        check_eq("t6b_d1", 32'(beat_data[s+1]), 32'h5001);
        check_eq("t6b_sop0", 32'(beat_sop[s]),   32'd1);
        check_eq("t6b_eop0", 32'(beat_eop[s]),   32'd0);
        check_eq("t6b_sop1", 32'(beat_sop[s+1]), 32'd0);
        check_eq("t6b_eop1", 32'(beat_eop[s+1]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
